restoring_divider_4bit: RTL and testbench

Sequential unsigned restoring divider, the inverse companion to the team's 4-bit ripple adder/subtractor. It takes a dividend and divisor, performs one shift-and-trial-subtract iteration per clock, and returns quotient and remainder with a done pulse. It sits beside the adder/subtractor in the arithmetic datapath library and reuses the same subtract-by-two's-complement principle for its trial step.

---
 rtl/arith_pkg.sv | 13 +
 rtl/trial_subtractor.sv | 20 ++
 rtl/restoring_divider_4bit.sv | 119 +++++++++++
 tb/tb_restoring_divider_4bit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types: divider FSM states and default width.
// Imported by the divider top and its trial subtractor.
package arith_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/trial_subtractor.sv
// Ripple-style adder/subtractor held in subtract mode for the divider trial.
// cout=1 means a >= b (no borrow).
module trial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  logic [WIDTH-1:0] bx;

  assign bx = b ^ {WIDTH{mode}};
  assign {cout, diff} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, mode};

endmodule

// File: rtl/restoring_divider_4bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results are registered on entry to DONE and held until the next one.
module restoring_divider_4bit
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] prem_nx;
  logic [WIDTH-1:0] q_nx;
  logic             cout;
  logic             accept;
  logic             last;
  logic             zdiv;
  logic             unused_msb;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign zdiv   = (divisor == '0);

  assign shifted = {prem, dsr[WIDTH-1]};

  trial_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a    (shifted),
    .b    ({1'b0, dvs}),
    .mode (1'b1),
    .diff (trial),
    .cout (cout)
  );

  // Partial remainder stays below divisor, so the MSB is always zero here.
  assign prem_nx    = cout ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_nx       = {qsr[WIDTH-2:0], cout};
  assign unused_msb = ^{trial[WIDTH], shifted[WIDTH]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = zdiv ? DONE : RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) state_nx = zdiv ? DONE : RUN;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prem        <= '0;
      qsr         <= '0;
      dsr         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      prem <= '0;
      qsr  <= '0;
      dsr  <= dividend;
      dvs  <= divisor;
      if (zdiv) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt  <= cnt + 1'b1;
      prem <= prem_nx;
      qsr  <= q_nx;
      dsr  <= {dsr[WIDTH-2:0], 1'b0};
      if (last) begin
        quotient    <= q_nx;
        remainder   <= prem_nx;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Directed and exhaustive checks for the 4-bit restoring divider.
// Expected values are hand-computed or come from integer / and %.
module tb_restoring_divider_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_chk;
  int n_fail;

  restoring_divider_4bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a request; returns 1 time unit after the accepting edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("timeout", {7'd0, done}, 8'd1);
  endtask

  task automatic expect_res(input string tag, input logic [3:0] q,
                            input logic [3:0] r, input logic z);
    check({tag, "_q"}, {4'd0, quotient}, {4'd0, q});
    check({tag, "_r"}, {4'd0, remainder}, {4'd0, r});
    check({tag, "_z"}, {7'd0, div_by_zero}, {7'd0, z});
  endtask

  initial begin
    int e;
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    expect_res("rst", 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 13/3 with cycle-exact timing
    start_op(4'd13, 4'd3);
    check("t13_busy0", {7'd0, busy}, 8'd1);
    check("t13_done0", {7'd0, done}, 8'd0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("t13_busy%0d", i), {7'd0, busy}, 8'd1);
      check($sformatf("t13_out%0d", i), {4'd0, quotient}, 8'd0);
    end
    @(posedge clk);
    #1;
    check("t13_done", {7'd0, done}, 8'd1);
    check("t13_busyd", {7'd0, busy}, 8'd0);
    expect_res("t13", 4'd4, 4'd1, 1'b0);
    @(posedge clk);
    #1;
    check("t13_pulse", {7'd0, done}, 8'd0);
    expect_res("t13_hold", 4'd4, 4'd1, 1'b0);

    start_op(4'd15, 4'd1);
    wait_done(e);
    expect_res("t15_1", 4'd15, 4'd0, 1'b0);
    start_op(4'd2, 4'd7);
    wait_done(e);
    expect_res("t2_7", 4'd0, 4'd2, 1'b0);
    start_op(4'd15, 4'd15);
    wait_done(e);
    expect_res("t15_15", 4'd1, 4'd0, 1'b0);

    // divide by zero finishes in the cycle after acceptance
    start_op(4'd9, 4'd0);
    check("dz_done", {7'd0, done}, 8'd1);
    check("dz_busy", {7'd0, busy}, 8'd0);
    expect_res("dz", 4'd15, 4'd9, 1'b1);

    // start during RUN is ignored
    start_op(4'd13, 4'd3);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(e);
    expect_res("ign", 4'd4, 4'd1, 1'b0);

    // back-to-back start in the DONE cycle
    start_op(4'd6, 4'd2);
    check("b2b_done", {7'd0, done}, 8'd0);
    check("b2b_busy", {7'd0, busy}, 8'd1);
    wait_done(e);
    check("b2b_lat", e[7:0], 8'd4);
    expect_res("b2b", 4'd3, 4'd0, 1'b0);

    // asynchronous reset in the 3rd RUN cycle
    start_op(4'd13, 4'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_busy", {7'd0, busy}, 8'd0);
    check("ar_done", {7'd0, done}, 8'd0);
    expect_res("ar", 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(4'd7, 4'd2);
    wait_done(e);
    expect_res("t7_2", 4'd3, 4'd1, 1'b0);

    // exhaustive sweep against integer division
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [7:0] qm, rm;
        start_op(4'(a), 4'(b));
        wait_done(e);
        if (b == 0) begin
          qm = 8'd15;
          rm = 8'(a);
        end else begin
          qm = 8'(a / b);
          rm = 8'(a % b);
          check($sformatf("inv_%0d_%0d", a, b),
                8'(quotient * 4'(b)) + 8'(remainder), 8'(a));
          check($sformatf("rlt_%0d_%0d", a, b),
                {7'd0, remainder < 4'(b)}, 8'd1);
        end
        check($sformatf("sq_%0d_%0d", a, b), {4'd0, quotient}, qm);
        check($sformatf("sr_%0d_%0d", a, b), {4'd0, remainder}, rm);
        check($sformatf("sz_%0d_%0d", a, b), {7'd0, div_by_zero},
              (b == 0) ? 8'd1 : 8'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
